// File: rtl/glitch_ctrl_pkg.sv
// Shared types and defaults for the TDL glitch-monitor controller.
// The state encoding is visible on the state port, so its values are fixed.
package glitch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_OBSERVE = 3'd2,
    ST_ARMED   = 3'd3,
    ST_HOLD    = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  localparam int unsigned DEF_NUM_DET    = 4;
  localparam int unsigned DEF_TAP_W      = 3;
  localparam int unsigned DEF_SETTLE_CYC = 8;
  localparam int unsigned DEF_CAL_CYC    = 256;
  localparam int unsigned DEF_MARGIN     = 1;
  localparam int unsigned DEF_DEBOUNCE   = 2;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_TS_W       = 32;

  function automatic int unsigned tap_minus_margin(input int unsigned tap,
                                                   input int unsigned margin);
    return (tap > margin) ? tap - margin : 0;
  endfunction

endpackage

// File: rtl/glitch_monitor_ctrl_debounce.sv
// Consecutive-alarm-cycle qualifier with an OR accumulator of the alarm bits
// seen in the current run; restart holds both at zero.
module glitch_debounce
  import glitch_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DET  = DEF_NUM_DET,
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic               clk_ps,
  input  logic               resetn,
  input  logic               restart,
  input  logic               active,
  input  logic [NUM_DET-1:0] alarm,
  output logic               qualify,
  output logic [NUM_DET-1:0] mask
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);

  logic [DB_W-1:0]    cnt_q;
  logic [NUM_DET-1:0] acc_q;
  logic               hit;

  assign hit     = |alarm;
  assign qualify = active && hit && (cnt_q == DB_W'(DEBOUNCE - 1));
  assign mask    = acc_q | alarm;

  always_ff @(posedge clk_ps) begin
    if (!resetn || restart) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (active) begin
      if (hit && !qualify) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= mask;
      end else begin
        cnt_q <= '0;
        acc_q <= '0;
      end
    end
  end

endmodule

// File: rtl/glitch_monitor_ctrl.sv
// Calibrates the shared TDL tap, then arms, debounces detector alarms and
// captures a sticky event record for the PS.
module glitch_monitor_ctrl
  import glitch_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DET    = DEF_NUM_DET,
  parameter int unsigned TAP_W      = DEF_TAP_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned CAL_CYC    = DEF_CAL_CYC,
  parameter int unsigned MARGIN     = DEF_MARGIN,
  parameter int unsigned DEBOUNCE   = DEF_DEBOUNCE,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned TS_W       = DEF_TS_W
) (
  input  logic               clk_ps,
  input  logic               resetn,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_DET-1:0] det_alarm,
  output logic               tdl_launch,
  output logic [TAP_W-1:0]   tap_sel,
  output logic [2:0]         state,
  output logic               calib_done,
  output logic               calib_fail,
  output logic               alarm_irq,
  output logic [NUM_DET-1:0] alarm_mask,
  output logic [CNT_W-1:0]   alarm_count,
  output logic [TS_W-1:0]    alarm_time
);

  localparam int unsigned TMR_MAX = (CAL_CYC > SETTLE_CYC) ? CAL_CYC : SETTLE_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic               done_q, done_d;
  logic               fail_q, fail_d;
  logic               launch_q, launch_d;
  logic [TS_W-1:0]    ts_q;
  logic               qualify;
  logic [NUM_DET-1:0] dbn_mask;

  glitch_debounce #(
    .NUM_DET  (NUM_DET),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk_ps  (clk_ps),
    .resetn  (resetn),
    .restart (state_q != ST_ARMED),
    .active  (state_q == ST_ARMED),
    .alarm   (det_alarm),
    .qualify (qualify),
    .mask    (dbn_mask)
  );

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    tap_d   = tap_q;
    done_d  = done_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          tap_d   = '1;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        timer_d = timer_q + 1'b1;
        // calib_done doubles as the "calibration complete" route flag
        if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
          timer_d = '0;
          state_d = done_q ? ST_ARMED : ST_OBSERVE;
        end
      end
      ST_OBSERVE: begin
        timer_d = timer_q + 1'b1;
        if (|det_alarm) begin
          timer_d = '0;
          if (tap_q != '0) begin
            tap_d   = tap_q - 1'b1;
            state_d = ST_SETTLE;
          end else begin
            fail_d  = 1'b1;
            state_d = ST_FAIL;
          end
        end else if (timer_q == TMR_W'(CAL_CYC - 1)) begin
          timer_d = '0;
          tap_d   = TAP_W'(tap_minus_margin(32'(tap_q), MARGIN));
          done_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_ARMED: if (qualify) state_d = ST_HOLD;
      ST_HOLD:  if (clear) state_d = ST_ARMED;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_IDLE;
    endcase
    // Dropping enable abandons the step in progress but keeps tap and flags.
    if (!enable) begin
      state_d = ST_IDLE;
      timer_d = '0;
      tap_d   = tap_q;
      done_d  = done_q;
      fail_d  = fail_q;
    end
    launch_d = (state_d == ST_SETTLE) || (state_d == ST_OBSERVE) ||
               (state_d == ST_ARMED)  || (state_d == ST_HOLD);
  end

  always_ff @(posedge clk_ps) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      tap_q    <= '1;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      launch_q <= 1'b0;
      ts_q     <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      tap_q    <= tap_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      launch_q <= launch_d;
      ts_q     <= ts_q + 1'b1;
    end
  end

  always_ff @(posedge clk_ps) begin
    if (!resetn) begin
      alarm_irq   <= 1'b0;
      alarm_mask  <= '0;
      alarm_count <= '0;
      alarm_time  <= '0;
    end else if (qualify) begin
      alarm_irq  <= 1'b1;
      alarm_mask <= dbn_mask;
      alarm_time <= ts_q;
      if (alarm_count != '1) alarm_count <= alarm_count + 1'b1;
    end else if (clear) begin
      alarm_irq <= 1'b0;
    end
  end

  assign tdl_launch = launch_q;
  assign tap_sel    = tap_q;
  assign state      = state_q;
  assign calib_done = done_q;
  assign calib_fail = fail_q;

endmodule

// File: tb/tb_glitch_monitor_ctrl.sv
// Directed bench for glitch_monitor_ctrl: calibration pass/step/fail, debounce,
// HOLD/clear handling, count saturation (CNT_W=2) and synchronous reset.
module tb_glitch_monitor_ctrl;
  import glitch_ctrl_pkg::*;

  logic        clk_ps = 1'b0;
  logic        resetn, enable, clear;
  logic [3:0]  det_alarm;
  logic        tdl_launch, calib_done, calib_fail, alarm_irq;
  logic [2:0]  tap_sel, state;
  logic [3:0]  alarm_mask;
  logic [1:0]  alarm_count;
  logic [31:0] alarm_time;
  logic [31:0] tb_ts;
  int          checks = 0;
  int          errors = 0;
  int          mode   = 0;
  int unsigned n;
  logic [31:0] exp_time;

  glitch_monitor_ctrl #(.CNT_W(2)) dut (
    .clk_ps      (clk_ps),
    .resetn      (resetn),
    .enable      (enable),
    .clear       (clear),
    .det_alarm   (det_alarm),
    .tdl_launch  (tdl_launch),
    .tap_sel     (tap_sel),
    .state       (state),
    .calib_done  (calib_done),
    .calib_fail  (calib_fail),
    .alarm_irq   (alarm_irq),
    .alarm_mask  (alarm_mask),
    .alarm_count (alarm_count),
    .alarm_time  (alarm_time)
  );

  always #5 clk_ps = ~clk_ps;

  always @(posedge clk_ps) begin
    if (!resetn) tb_ts <= '0;
    else         tb_ts <= tb_ts + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ps);
    @(negedge clk_ps);
  endtask

  task automatic drive_alarm();
    case (mode)
      1:       det_alarm = (state == ST_OBSERVE && tap_sel >= 3'd5) ? 4'b0001 : 4'b0000;
      2:       det_alarm = 4'b0001;
      default: det_alarm = 4'b0000;
    endcase
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target,
                            input int unsigned limit, output int unsigned cnt);
    cnt = 0;
    while (state !== target && cnt < limit) begin
      drive_alarm();
      tick();
      cnt++;
    end
    chk(tag, 64'(state), 64'(target));
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; clear = 1'b0; det_alarm = '0;
    repeat (3) tick();
    chk("rst_state",  64'(state),       64'(ST_IDLE));
    chk("rst_tap",    64'(tap_sel),     64'd7);
    chk("rst_launch", 64'(tdl_launch),  64'd0);
    chk("rst_flags",  64'({calib_done, calib_fail, alarm_irq}), 64'd0);
    chk("rst_count",  64'(alarm_count), 64'd0);
    resetn = 1'b1;
    tick();

    // Clean calibration: 8 settle + 256 observe + 8 settle -> ARMED at tap 6
    enable = 1'b1;
    tick();
    chk("cal_settle", 64'(state),      64'(ST_SETTLE));
    chk("cal_tap7",   64'(tap_sel),    64'd7);
    chk("cal_launch", 64'(tdl_launch), 64'd1);
    wait_state("cal_armed", ST_ARMED, 400, n);
    chk("cal_cycles", 64'(n),          64'd272);
    chk("cal_tap6",   64'(tap_sel),    64'd6);
    chk("cal_done",   64'(calib_done), 64'd1);
    chk("cal_launch2",64'(tdl_launch), 64'd1);

    // Single-cycle pulse does not qualify
    det_alarm = 4'b0010; tick();
    det_alarm = 4'b0000; tick(); tick();
    chk("pulse_irq",   64'(alarm_irq), 64'd0);
    chk("pulse_state", 64'(state),     64'(ST_ARMED));

    // Two consecutive alarm cycles qualify; mask ORs both
    det_alarm = 4'b0010; tick();
    det_alarm = 4'b0100; exp_time = tb_ts; tick();
    chk("ev1_irq",   64'(alarm_irq),   64'd1);
    chk("ev1_mask",  64'(alarm_mask),  64'b0110);
    chk("ev1_count", 64'(alarm_count), 64'd1);
    chk("ev1_time",  64'(alarm_time),  64'(exp_time));
    chk("ev1_state", 64'(state),       64'(ST_HOLD));

    // HOLD ignores alarms
    det_alarm = 4'b1111; tick();
    det_alarm = 4'b0000; tick();
    det_alarm = 4'b1010; tick();
    chk("hold_count", 64'(alarm_count), 64'd1);
    chk("hold_mask",  64'(alarm_mask),  64'b0110);
    chk("hold_time",  64'(alarm_time),  64'(exp_time));
    chk("hold_state", 64'(state),       64'(ST_HOLD));

    // clear wins over held alarm; debounce restarts, irq back 2 cycles later
    det_alarm = 4'b1111; clear = 1'b1; tick();
    clear = 1'b0;
    chk("clr_state", 64'(state),     64'(ST_ARMED));
    chk("clr_irq",   64'(alarm_irq), 64'd0);
    tick();
    chk("clr_irq1",  64'(alarm_irq), 64'd0);
    tick();
    chk("clr_irq2",  64'(alarm_irq),   64'd1);
    chk("ev2_count", 64'(alarm_count), 64'd2);
    chk("ev2_mask",  64'(alarm_mask),  64'b1111);

    // Third and fourth events: 2-bit count saturates at 3
    det_alarm = 4'b0000; clear = 1'b1; tick(); clear = 1'b0;
    det_alarm = 4'b1000; tick(); tick();
    chk("ev3_count", 64'(alarm_count), 64'd3);
    det_alarm = 4'b0000; clear = 1'b1; tick(); clear = 1'b0;
    det_alarm = 4'b1000; tick(); tick();
    chk("sat_count", 64'(alarm_count), 64'd3);
    chk("sat_state", 64'(state),       64'(ST_HOLD));
    chk("sat_mask",  64'(alarm_mask),  64'b1000);

    // enable=0 -> IDLE, alarm fields and calibration retained
    det_alarm = 4'b0000; enable = 1'b0; tick();
    chk("dis_state",  64'(state),      64'(ST_IDLE));
    chk("dis_launch", 64'(tdl_launch), 64'd0);
    chk("dis_irq",    64'(alarm_irq),  64'd1);
    chk("dis_tap",    64'(tap_sel),    64'd6);
    chk("dis_done",   64'(calib_done), 64'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("idle_clr_irq",   64'(alarm_irq), 64'd0);
    chk("idle_clr_state", 64'(state),     64'(ST_IDLE));

    // Stepped calibration: alarms while tap>=5 -> accepts 4, settles at 3
    enable = 1'b1; mode = 1; tick();
    chk("step_done_clr", 64'(calib_done), 64'd0);
    wait_state("step_armed", ST_ARMED, 3000, n);
    chk("step_tap",  64'(tap_sel),     64'd3);
    chk("step_done", 64'(calib_done),  64'd1);
    chk("step_cnt",  64'(alarm_count), 64'd3);
    mode = 0; det_alarm = '0;

    // Permanent alarm: steps to tap 0 then FAIL
    enable = 1'b0; tick();
    enable = 1'b1; mode = 2; tick();
    wait_state("fail_state", ST_FAIL, 500, n);
    chk("fail_flag",   64'(calib_fail), 64'd1);
    chk("fail_tap",    64'(tap_sel),    64'd0);
    chk("fail_launch", 64'(tdl_launch), 64'd0);
    chk("fail_done",   64'(calib_done), 64'd0);
    enable = 1'b0; mode = 0; det_alarm = '0; tick();
    chk("fail_idle", 64'(state), 64'(ST_IDLE));

    // Reset in the middle of OBSERVE
    enable = 1'b1; tick();
    wait_state("obs_reach", ST_OBSERVE, 50, n);
    repeat (3) tick();
    resetn = 1'b0; tick();
    chk("mrst_state",  64'(state),       64'(ST_IDLE));
    chk("mrst_tap",    64'(tap_sel),     64'd7);
    chk("mrst_launch", 64'(tdl_launch),  64'd0);
    chk("mrst_flags",  64'({calib_done, calib_fail, alarm_irq}), 64'd0);
    chk("mrst_mask",   64'(alarm_mask),  64'd0);
    chk("mrst_count",  64'(alarm_count), 64'd0);
    chk("mrst_time",   64'(alarm_time),  64'd0);
    resetn = 1'b1; enable = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/glitch_monitor_ctrl.md
Name: glitch_monitor_ctrl

Overview:
- Sequences and supervises an array of carry-chain (TDL) voltage-glitch detectors sharing one configurable delay-line tap select.
- Drives the common TDL launch signal and calibrates the tap: picks the longest delay that stays alarm-free at nominal supply.
- Then arms, debounces raw detector alarms, captures event context and raises a sticky interrupt toward the PS.

Parameters:
- NUM_DET, 4, number of detector alarm inputs.
- TAP_W, 3, tap select width; taps 0..2^TAP_W-1, higher = longer chain.
- SETTLE_CYC, 8, cycles waited after a tap change or launch rise before observing.
- CAL_CYC, 256, alarm-free observe cycles needed to accept a tap.
- MARGIN, 1, taps subtracted from the passing tap (saturates at 0).
- DEBOUNCE, 2, consecutive alarm cycles needed to qualify an event (>=1).
- CNT_W, 16, event counter width.
- TS_W, 32, timestamp width.

Ports:
- clk_ps  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  level; 1 = run calibrate/arm sequence, 0 = return to IDLE.
- clear  in  1  single-cycle pulse; acknowledges the event.
- det_alarm  in  NUM_DET  registered raw detector alarms (1 = chain output late).
- tdl_launch  out  1  drives every detector's tdl_in.
- tap_sel  out  TAP_W  delay-line length select.
- state  out  3  current FSM state encoding.
- calib_done  out  1  tap accepted.
- calib_fail  out  1  no tap passed.
- alarm_irq  out  1  sticky qualified-event flag.
- alarm_mask  out  NUM_DET  OR of det_alarm over the qualifying window.
- alarm_count  out  CNT_W  saturating qualified-event count.
- alarm_time  out  TS_W  timestamp at qualification.

Behaviour:
- Reset values: tdl_launch=0, tap_sel=all-ones, state=IDLE, all flags, mask, count and time 0. Timestamp counter=0.
- Timestamp counter: free-running +1 per cycle, wraps modulo 2^TS_W.
- State encoding: IDLE=0, SETTLE=1, OBSERVE=2, ARMED=3, HOLD=4, FAIL=5.
- IDLE: tdl_launch=0; det_alarm ignored. On enable=1: tap_sel=max, clear calib_done and calib_fail, go to SETTLE.
- SETTLE: tdl_launch=1; after SETTLE_CYC cycles go to OBSERVE with the observe counter cleared.
- OBSERVE:
  - Any det_alarm bit set ends OBSERVE early. If tap_sel>0: tap_sel-1, go to SETTLE. If tap_sel=0: calib_fail=1, go to FAIL.
  - After CAL_CYC clean cycles: tap_sel=max(tap_sel-MARGIN,0), calib_done=1, go to SETTLE-then-ARMED. The settle is mandatory because the tap changed; a flag marks that calibration is complete, so the next SETTLE exit goes to ARMED.
- ARMED:
  - Debounce counter increments while |det_alarm; any clean cycle resets it to 0.
  - mask_acc ORs det_alarm; it is cleared whenever the debounce counter resets.
  - When the counter reaches DEBOUNCE, the same edge does all of: alarm_irq=1, alarm_mask=mask_acc|det_alarm, alarm_time=timestamp, alarm_count+1 (saturate at all-ones); go to HOLD.
- HOLD: det_alarm ignored; outputs frozen. On clear: alarm_irq=0, debounce state reset, go to ARMED.
- FAIL: tdl_launch=0; stays until enable=0.
- enable=0 in any state: next cycle IDLE and tdl_launch=0. tap_sel, calib flags, alarm_irq, mask, count and time are all retained.
- Re-enable restarts the full calibration. calib_done and calib_fail clear; the alarm fields do not.
- clear in states other than HOLD: clears alarm_irq only; no state change.
- Simultaneous events:
  - clear and enable=0 together: both act.
  - clear in HOLD together with asserted det_alarm: clear wins; debounce restarts from 0 next cycle.
  - Qualification edge coinciding with enable=0: the event is captured, then the FSM goes to IDLE.
- alarm_count and alarm_mask are cleared only by resetn.
- Latency: tdl_launch and tap_sel change one cycle after the state decision. alarm_irq asserts on the edge where the DEBOUNCE-th consecutive alarm cycle is sampled.
- det_alarm is already in the clk_ps domain; no synchroniser.

Decomposition:
- Package glitch_ctrl_pkg:
  - state enum and its 3-bit encoding;
  - default parameter constants;
  - function computing the saturating tap-minus-margin.
- Sub-module glitch_debounce: consecutive-cycle counter plus mask accumulator, with a qualify output and a restart input. One instance.

Test Plan:
- Reset, enable=1, det_alarm=0 throughout -> tap_sel 7; calib_done=1 after 8+256+8 cycles; final tap_sel=6; state=ARMED; tdl_launch=1.
- det_alarm[0] high during OBSERVE while tap_sel>=5, clean below -> tap_sel steps 7,6,5,4; final tap_sel=3; calib_done=1.
- det_alarm=4'b0001 held through all OBSERVE windows -> tap_sel reaches 0, calib_fail=1, state=FAIL, tdl_launch=0; enable=0 -> IDLE.
- ARMED:
  - 1-cycle pulse of 4'b0010 -> no irq.
  - 4'b0010 then 4'b0100 on consecutive cycles -> alarm_irq=1, alarm_mask=4'b0110, alarm_count=1, alarm_time=timestamp at the qualifying edge, state=HOLD.
- In HOLD, det_alarm toggling -> count stays 1. clear with det_alarm=4'b1111 held -> ARMED; irq re-asserts exactly 2 cycles later; count=2.
- Force alarm_count to all-ones via 65535 events (or reduce CNT_W to 2 and run 3 events) -> count saturates at 3. Assert resetn=0 mid-OBSERVE -> every output returns to its reset value on the next edge.
